// File: rtl/localbus_reg_target.sv
// Localbus responder: executes WR/RD/SET/CLR commands against control registers and status
// words, one response per command. Define LB_ERRCNT_EN to add a clearable error counter.
module localbus_reg_target #(
   parameter int unsigned         LBCWIDTH = 8,
   parameter int unsigned         LBAWIDTH = 24,
   parameter int unsigned         LBDWIDTH = 32,
   parameter logic [LBAWIDTH-1:0] BASE     = 24'h000100,
   parameter int unsigned         NREG     = 16,
   parameter int unsigned         NSTAT    = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      lb_valid,
   output logic                      lb_ready,
   input  logic [LBCWIDTH-1:0]       lb_cmd,
   input  logic [LBAWIDTH-1:0]       lb_addr,
   input  logic [LBDWIDTH-1:0]       lb_wdata,
   output logic                      lb_rvalid,
   input  logic                      lb_rready,
   output logic [LBDWIDTH-1:0]       lb_rdata,
   output logic [1:0]                lb_rstat,
   output logic [NREG*LBDWIDTH-1:0]  regs,
   output logic [NREG-1:0]           reg_wstb,
   input  logic [NSTAT*LBDWIDTH-1:0] stat
);

   localparam int unsigned IDXW  = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned SIDXW = (NSTAT > 1) ? $clog2(NSTAT) : 1;

   localparam logic [LBCWIDTH-1:0] CmdWr  = LBCWIDTH'(1);
   localparam logic [LBCWIDTH-1:0] CmdRd  = LBCWIDTH'(2);
   localparam logic [LBCWIDTH-1:0] CmdSet = LBCWIDTH'(3);
   localparam logic [LBCWIDTH-1:0] CmdClr = LBCWIDTH'(4);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t              state;
   logic [LBCWIDTH-1:0] cmd_q;
   logic [LBAWIDTH-1:0] addr_q;
   logic [LBDWIDTH-1:0] wdata_q;
   logic [LBDWIDTH-1:0] reg_q  [NREG];
   logic [LBDWIDTH-1:0] stat_w [NSTAT];

   logic [LBAWIDTH-1:0] off;
   logic [IDXW-1:0]     ridx;
   logic [SIDXW-1:0]    sidx;
   logic                cmd_ok;
   logic [LBDWIDTH-1:0] cur;
   logic [LBDWIDTH-1:0] ex_rdata;
   logic [LBDWIDTH-1:0] ex_wval;
   logic [1:0]          ex_rstat;
   logic                ex_wen;

   for (genvar i = 0; i < NREG; i++) begin : g_regs
      assign regs[i*LBDWIDTH +: LBDWIDTH] = reg_q[i];
   end
   for (genvar i = 0; i < NSTAT; i++) begin : g_stat
      assign stat_w[i] = stat[i*LBDWIDTH +: LBDWIDTH];
   end

   // Unsigned wrap makes any address below BASE land far out of range.
   assign off    = addr_q - BASE;
   assign ridx   = IDXW'(off);
   assign sidx   = SIDXW'(off - LBAWIDTH'(NREG));
   assign cmd_ok = (cmd_q == CmdWr) || (cmd_q == CmdRd) || (cmd_q == CmdSet) ||
                   (cmd_q == CmdClr);
   assign cur    = reg_q[ridx];

`ifdef LB_ERRCNT_EN
   logic [LBDWIDTH-1:0] errcnt_q;
   logic                ex_errclr;
`endif

   always_comb begin
      ex_rdata = '0;
      ex_rstat = 2'd0;
      ex_wen   = 1'b0;
      ex_wval  = '0;
`ifdef LB_ERRCNT_EN
      ex_errclr = 1'b0;
`endif
      if (!cmd_ok) begin
         ex_rstat = 2'd2;
      end else if (off < LBAWIDTH'(NREG)) begin
         case (cmd_q)
            CmdWr:   ex_wval = wdata_q;
            CmdSet:  ex_wval = cur | wdata_q;
            CmdClr:  ex_wval = cur & ~wdata_q;
            default: ex_wval = cur;
         endcase
         ex_wen   = (cmd_q != CmdRd);
         ex_rdata = ex_wval;
      end else if (off < LBAWIDTH'(NREG + NSTAT)) begin
         if (cmd_q == CmdRd) ex_rdata = stat_w[sidx];
         else                ex_rstat = 2'd1;
`ifdef LB_ERRCNT_EN
      end else if (off == LBAWIDTH'(NREG + NSTAT)) begin
         if (cmd_q == CmdRd)      ex_rdata  = errcnt_q;
         else if (cmd_q == CmdWr) ex_errclr = 1'b1;
         else                     ex_rstat  = 2'd1;
`endif
      end else begin
         ex_rstat = 2'd1;
      end
   end

`ifdef LB_ERRCNT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         errcnt_q <= '0;
      end else if (state == StExec) begin
         if (ex_errclr)                               errcnt_q <= '0;
         else if (ex_rstat != 2'd0 && errcnt_q != '1) errcnt_q <= errcnt_q + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= StIdle;
         lb_ready  <= 1'b0;
         lb_rvalid <= 1'b0;
         lb_rdata  <= '0;
         lb_rstat  <= 2'd0;
         reg_wstb  <= '0;
         cmd_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
      end else begin
         reg_wstb <= '0;
         unique case (state)
            StIdle: begin
               lb_ready <= 1'b1;
               if (lb_valid && lb_ready) begin
                  cmd_q    <= lb_cmd;
                  addr_q   <= lb_addr;
                  wdata_q  <= lb_wdata;
                  lb_ready <= 1'b0;
                  state    <= StExec;
               end
            end
            StExec: begin
               lb_rdata  <= ex_rdata;
               lb_rstat  <= ex_rstat;
               lb_rvalid <= 1'b1;
               if (ex_wen) begin
                  reg_q[ridx]    <= ex_wval;
                  reg_wstb[ridx] <= 1'b1;
               end
               state <= StResp;
            end
            StResp: begin
               if (lb_rready) begin
                  lb_rvalid <= 1'b0;
                  lb_ready  <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_localbus_reg_target.sv
// Randomised bench for localbus_reg_target against a behavioural register-bank model.
// Honours LB_ERRCNT_EN the same way as the design.
module tb_localbus_reg_target;

   localparam int          NREG  = 16;
   localparam int          NSTAT = 8;
   localparam logic [23:0] BASE  = 24'h000100;

   logic         clk = 1'b0;
   logic         rstn;
   logic         lb_valid, lb_ready, lb_rvalid, lb_rready;
   logic [7:0]   lb_cmd;
   logic [23:0]  lb_addr;
   logic [31:0]  lb_wdata, lb_rdata;
   logic [1:0]   lb_rstat;
   logic [511:0] regs;
   logic [15:0]  reg_wstb;
   logic [255:0] m_stat;

   // Reference model state and expected response of the last issued command
   logic [511:0] m_regs;
   logic [31:0]  m_err;
   logic [31:0]  e_rdata;
   logic [1:0]   e_rstat;
   logic [15:0]  e_wstb;
   int           n_vec = 0;
   int           n_err = 0;

   localbus_reg_target dut (
      .clk       (clk),
      .rstn      (rstn),
      .lb_valid  (lb_valid),
      .lb_ready  (lb_ready),
      .lb_cmd    (lb_cmd),
      .lb_addr   (lb_addr),
      .lb_wdata  (lb_wdata),
      .lb_rvalid (lb_rvalid),
      .lb_rready (lb_rready),
      .lb_rdata  (lb_rdata),
      .lb_rstat  (lb_rstat),
      .regs      (regs),
      .reg_wstb  (reg_wstb),
      .stat      (m_stat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
      logic [23:0] offv;
      int          o;
      logic [31:0] v;
      offv    = a - BASE;
      o       = int'(offv);
      e_rdata = '0;
      e_rstat = 2'd0;
      e_wstb  = '0;
      if (c == 0 || c > 4) begin
         e_rstat = 2'd2;
      end else if (o < NREG) begin
         v = m_regs[o*32 +: 32];
         if (c == 8'h01) v = d;
         if (c == 8'h03) v = v | d;
         if (c == 8'h04) v = v & ~d;
         e_rdata = v;
         if (c != 8'h02) begin
            m_regs[o*32 +: 32] = v;
            e_wstb[o] = 1'b1;
         end
      end else if (o < NREG + NSTAT) begin
         if (c == 8'h02) e_rdata = m_stat[(o-NREG)*32 +: 32];
         else            e_rstat = 2'd1;
`ifdef LB_ERRCNT_EN
      end else if (o == NREG + NSTAT) begin
         if (c == 8'h02)      e_rdata = m_err;
         else if (c == 8'h01) m_err = 0;
         else                 e_rstat = 2'd1;
`endif
      end else begin
         e_rstat = 2'd1;
      end
      if (e_rstat != 0 && m_err != 32'hFFFF_FFFF) m_err = m_err + 1;
   endtask

   // Called at a negedge; returns 1 ns after the accepting posedge.
   task automatic send(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
      int n = 0;
      lb_valid = 1'b1;
      lb_cmd   = c;
      lb_addr  = a;
      lb_wdata = d;
      while (!lb_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!lb_ready) begin
         check("ready_timeout", 0, 1);
         lb_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 lb_valid = 1'b0;
      model(c, a, d);
   endtask

   // Checks the response; hold stalls lb_rready. Returns at a negedge.
   task automatic collect(input int hold);
      @(negedge clk);
      check("exec_rvalid", lb_rvalid, 0);
      @(negedge clk);
      check("rvalid", lb_rvalid, 1);
      check("rdata", lb_rdata, e_rdata);
      check("rstat", lb_rstat, e_rstat);
      check("wstb", reg_wstb, e_wstb);
      check("regs", regs, m_regs);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_rvalid", lb_rvalid, 1);
         check("hold_rdata", lb_rdata, e_rdata);
         check("hold_rstat", lb_rstat, e_rstat);
         check("hold_ready", lb_ready, 0);
         check("hold_wstb", reg_wstb, 0);
      end
      lb_rready = 1'b1;
      @(posedge clk);
      #1 lb_rready = 1'b0;
      @(negedge clk);
      check("post_rvalid", lb_rvalid, 0);
      check("post_wstb", reg_wstb, 0);
      check("post_ready", lb_ready, 1);
   endtask

   task automatic xact(input logic [7:0] c, input logic [23:0] a, input logic [31:0] d,
                       input int hold);
      send(c, a, d);
      collect(hold);
   endtask

   initial begin
      rstn      = 1'b0;
      lb_valid  = 1'b0;
      lb_rready = 1'b0;
      lb_cmd    = '0;
      lb_addr   = '0;
      lb_wdata  = '0;
      m_regs    = '0;
      m_err     = '0;
      for (int i = 0; i < NSTAT; i++) m_stat[i*32 +: 32] = $urandom;
      m_stat[2*32 +: 32] = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check("rst_ready", lb_ready, 0);
      check("rst_rvalid", lb_rvalid, 0);
      check("rst_rdata", lb_rdata, 0);
      check("rst_rstat", lb_rstat, 0);
      check("rst_regs", regs, 0);
      check("rst_wstb", reg_wstb, 0);
      rstn = 1'b1;
      @(negedge clk);

      xact(8'h01, BASE + 3, 32'hDEAD_BEEF, 0);
      check("wr3_wstb", e_wstb, 16'h0008);
      xact(8'h02, BASE + 3, 32'h0, 0);
      check("rd3_data", lb_rdata, 32'hDEAD_BEEF);
      xact(8'h01, BASE, 32'h0000_000F, 0);
      xact(8'h03, BASE, 32'h0000_00F0, 1);
      check("set_val", e_rdata, 32'h0000_00FF);
      xact(8'h04, BASE, 32'h0000_0030, 0);
      check("clr_val", e_rdata, 32'h0000_00CF);
      xact(8'h02, BASE + NREG + 2, 32'h0, 0);
      check("stat2_val", e_rdata, 32'h1234_5678);
      xact(8'h01, BASE + NREG + 2, 32'hFFFF_FFFF, 0);
      xact(8'h02, 24'h0000FF, 32'h0, 0);
      xact(8'h7F, BASE, 32'hFFFF_FFFF, 0);
      xact(8'h01, BASE + NREG + NSTAT + 1, 32'h1, 0);

      // Stalled response with a second command waiting behind it
      send(8'h01, BASE + 5, 32'hA5A5_0001);
      @(negedge clk);
      @(negedge clk);
      check("stall_rdata0", lb_rdata, e_rdata);
      lb_valid = 1'b1;
      lb_cmd   = 8'h02;
      lb_addr  = BASE + 5;
      lb_wdata = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_rvalid", lb_rvalid, 1);
         check("stall_rdata", lb_rdata, e_rdata);
         check("stall_ready", lb_ready, 0);
      end
      lb_rready = 1'b1;
      @(posedge clk);
      #1 lb_rready = 1'b0;
      @(negedge clk);
      check("stall_post_rvalid", lb_rvalid, 0);
      check("stall_post_ready", lb_ready, 1);
      xact(8'h02, BASE + 5, 32'h0, 0);
      check("stall_rd", lb_rdata, 32'hA5A5_0001);

      // Reset while the command is in EXEC
      send(8'h01, BASE + 1, 32'h5555_5555);
      #1 rstn = 1'b0;
      #1;
      m_regs = '0;
      m_err  = '0;
      check("mid_ready", lb_ready, 0);
      check("mid_rvalid", lb_rvalid, 0);
      check("mid_rdata", lb_rdata, 0);
      check("mid_rstat", lb_rstat, 0);
      check("mid_regs", regs, 0);
      check("mid_wstb", reg_wstb, 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("mid_no_resp", lb_rvalid, 0);
      end

`ifdef LB_ERRCNT_EN
      repeat (3) xact(8'h55, BASE, 32'h0, 0);
      xact(8'h02, BASE + NREG + NSTAT, 32'h0, 0);
      check("errcnt_3", lb_rdata, 32'd3);
      xact(8'h01, BASE + NREG + NSTAT, 32'h1234, 0);
      check("errcnt_wr_stat", lb_rstat, 0);
      xact(8'h02, BASE + NREG + NSTAT, 32'h0, 0);
      check("errcnt_0", lb_rdata, 32'd0);
`endif

      for (int k = 0; k < 300; k++) begin
         logic [7:0] c;
         int         pick;
         pick = $urandom_range(0, 9);
         if (pick < 8) c = 8'((pick % 4) + 1);
         else          c = 8'($urandom);
         if (k % 16 == 0) for (int i = 0; i < NSTAT; i++) m_stat[i*32 +: 32] = $urandom;
         xact(c, BASE - 2 + 24'($urandom_range(0, NREG + NSTAT + 4)), $urandom,
              $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
